// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared widths, state encoding and helpers for the CPU16
//                instruction-fetch sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_ctrl_pkg;

   // Default PC / ROM address width and instruction word width
   localparam int C_ADDR_W = 16;
   localparam int C_DATA_W = 16;

   // Fetch sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,  // first cycle after reset
      ST_SETTLE = 3'd1,  // wait for pc_addr to reflect the last inc/load
      ST_REQ    = 3'd2,  // ROM read outstanding, result wanted
      ST_HOLD   = 3'd3,  // fetched word presented to decode
      ST_DRAIN  = 3'd4   // ROM read outstanding, result to be discarded
   } fetch_state_t;

   // True in the states where an rom_ack belongs to a request we issued
   function automatic logic rom_owned(input fetch_state_t s);
      return (s == ST_REQ) || (s == ST_DRAIN);
   endfunction

endpackage : fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. Captures the PC address, reads
//                ROM over req/ack, hands words to decode over valid/ready and
//                redirects the PC on taken jumps, flushing wrong-path fetches.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int ADDR_W = C_ADDR_W,
   parameter int DATA_W = C_DATA_W
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_addr,
   output logic              pc_load,
   output logic              pc_inc,
   output logic [ADDR_W-1:0] pc_target,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_ack,
   input  logic [DATA_W-1:0] rom_data,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   input  logic              instr_ready,
   input  logic              jmp_req,
   input  logic [ADDR_W-1:0] jmp_target
);

   // Registered state and outputs
   fetch_state_t      r_state;
   logic              r_pc_load;
   logic              r_pc_inc;
   logic [ADDR_W-1:0] r_pc_target;
   logic              r_rom_req;
   logic [ADDR_W-1:0] r_rom_addr;
   logic              r_instr_valid;
   logic [DATA_W-1:0] r_instr;

   // Next-state values
   fetch_state_t      w_state;
   logic              w_pc_load;
   logic              w_pc_inc;
   logic [ADDR_W-1:0] w_pc_target;
   logic              w_rom_req;
   logic [ADDR_W-1:0] w_rom_addr;
   logic              w_instr_valid;
   logic [DATA_W-1:0] w_instr;

   // A pc_load/pc_inc pulse currently on the outputs has not reached the PC
   // yet, so pc_addr is stale for one more cycle.
   logic              w_pc_busy;
   // rom_ack that answers a request we actually issued
   logic              w_ack_live;

   assign w_pc_busy  = r_pc_load | r_pc_inc;
   assign w_ack_live = rom_ack & rom_owned(r_state);

   // Next-state and next-output decode; jmp_req > rom_ack > instr_ready
   always_comb begin
      w_state       = r_state;
      w_pc_load     = 1'b0;
      w_pc_inc      = 1'b0;
      w_pc_target   = r_pc_target;
      w_rom_req     = r_rom_req;
      w_rom_addr    = r_rom_addr;
      w_instr_valid = r_instr_valid;
      w_instr       = r_instr;

      case (r_state)
         ST_IDLE: begin
            w_state = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (jmp_req) begin
               w_pc_load   = 1'b1;
               w_pc_target = jmp_target;
            end else if (!w_pc_busy) begin
               w_rom_addr = pc_addr;
               w_rom_req  = 1'b1;
               w_state    = ST_REQ;
            end
         end

         ST_REQ: begin
            if (jmp_req) begin
               w_pc_load   = 1'b1;
               w_pc_target = jmp_target;
               if (w_ack_live) begin
                  // Wrong-path data arrived with the jump: drop it
                  w_rom_req = 1'b0;
                  w_state   = ST_SETTLE;
               end else begin
                  // Leave the request outstanding and discard its answer later
                  w_state = ST_DRAIN;
               end
            end else if (w_ack_live) begin
               w_instr       = rom_data;
               w_instr_valid = 1'b1;
               w_pc_inc      = 1'b1;
               w_rom_req     = 1'b0;
               w_state       = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (jmp_req) begin
               // Held word is wrong-path; it is withdrawn, not handed over
               w_instr_valid = 1'b0;
               w_pc_load     = 1'b1;
               w_pc_target   = jmp_target;
               w_state       = ST_SETTLE;
            end else if (instr_ready) begin
               w_instr_valid = 1'b0;
               w_state       = ST_SETTLE;
            end
         end

         ST_DRAIN: begin
            if (jmp_req) begin
               // Latest jump wins
               w_pc_load   = 1'b1;
               w_pc_target = jmp_target;
            end
            if (w_ack_live) begin
               w_rom_req = 1'b0;
               w_state   = ST_SETTLE;
            end
         end

         default: begin
            w_state       = ST_IDLE;
            w_rom_req     = 1'b0;
            w_instr_valid = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_pc_load     <= 1'b0;
         r_pc_inc      <= 1'b0;
         r_pc_target   <= '0;
         r_rom_req     <= 1'b0;
         r_rom_addr    <= '0;
         r_instr_valid <= 1'b0;
         r_instr       <= '0;
      end else begin
         r_state       <= w_state;
         r_pc_load     <= w_pc_load;
         r_pc_inc      <= w_pc_inc;
         r_pc_target   <= w_pc_target;
         r_rom_req     <= w_rom_req;
         r_rom_addr    <= w_rom_addr;
         r_instr_valid <= w_instr_valid;
         r_instr       <= w_instr;
      end
   end

   assign pc_load     = r_pc_load;
   assign pc_inc      = r_pc_inc;
   assign pc_target   = r_pc_target;
   assign rom_req     = r_rom_req;
   assign rom_addr    = r_rom_addr;
   assign instr_valid = r_instr_valid;
   assign instr       = r_instr;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl with a PC model, a ROM
//                responder of programmable latency and a scoreboard of
//                expected ROM addresses, instructions and jump targets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

   logic        clock;
   logic        reset;
   logic [15:0] pc;
   logic        pc_load;
   logic        pc_inc;
   logic [15:0] pc_target;
   logic        rom_req;
   logic [15:0] rom_addr;
   logic        rom_ack;
   logic [15:0] rom_data;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic        jmp_req;
   logic [15:0] jmp_target;

   // Bench knobs
   logic [15:0] pc_rst_val;
   int          rom_lat;
   logic        rom_inject;
   int          rom_cnt;

   // Scoreboard
   logic [15:0] q_addr[$];
   logic [15:0] q_instr[$];
   logic [15:0] q_tgt[$];
   int          n_cmp;
   int          n_err;
   int          n_accept;
   int          n_inc;
   int          n_load;

   // Monitor history
   logic        prev_req;
   logic        prev_valid;
   logic [15:0] held_addr;
   logic [15:0] held_instr;

   fetch_ctrl #(.ADDR_W(16), .DATA_W(16)) u_dut (
      .clock       (clock),
      .reset       (reset),
      .pc_addr     (pc),
      .pc_load     (pc_load),
      .pc_inc      (pc_inc),
      .pc_target   (pc_target),
      .rom_req     (rom_req),
      .rom_addr    (rom_addr),
      .rom_ack     (rom_ack),
      .rom_data    (rom_data),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .jmp_req     (jmp_req),
      .jmp_target  (jmp_target)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ROM contents: a bijection of the address so every word is distinct
   function automatic logic [15:0] rom_fn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC35A;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // PC register model: loads/increments on the edge after the pulse
   always @(posedge clock) begin
      if (reset)        pc <= pc_rst_val;
      else if (pc_load) pc <= pc_target;
      else if (pc_inc)  pc <= pc + 16'd1;
   end

   // ROM responder: ack rom_lat cycles after it first sees rom_req
   initial begin
      rom_ack  = 1'b0;
      rom_data = 16'h0000;
      rom_cnt  = 0;
      forever begin
         @(posedge clock);
         #2;
         if (reset) begin
            rom_ack = 1'b0;
            rom_cnt = 0;
         end else if (rom_inject) begin
            rom_ack  = 1'b1;
            rom_data = 16'hDEAD;
         end else if (rom_ack) begin
            rom_ack = 1'b0;
         end else if (rom_req) begin
            if (rom_cnt >= rom_lat) begin
               rom_ack  = 1'b1;
               rom_data = rom_fn(rom_addr);
               rom_cnt  = 0;
            end else begin
               rom_cnt++;
            end
         end else begin
            rom_cnt = 0;
         end
      end
   end

   // Monitor: scoreboard pops, hold-stability and pulse exclusivity
   initial begin
      prev_req   = 1'b0;
      prev_valid = 1'b0;
      held_addr  = 16'h0;
      held_instr = 16'h0;
      forever begin
         @(posedge clock);
         #3;
         if (pc_load || pc_inc)
            check_val("pc_excl", 32'(pc_load & pc_inc), 32'd0);
         if (pc_inc) n_inc++;
         if (pc_load) begin
            n_load++;
            if (q_tgt.size() > 0) check_val("pc_target", 32'(pc_target), 32'(q_tgt.pop_front()));
         end
         if (rom_req && !prev_req) begin
            held_addr = rom_addr;
            if (q_addr.size() > 0) check_val("rom_addr", 32'(rom_addr), 32'(q_addr.pop_front()));
         end else if (rom_req && prev_req) begin
            check_val("rom_addr_hold", 32'(rom_addr), 32'(held_addr));
         end
         if (instr_valid && !prev_valid) held_instr = instr;
         else if (instr_valid && prev_valid) check_val("instr_hold", 32'(instr), 32'(held_instr));
         if (instr_valid && instr_ready && !jmp_req && !reset) begin
            n_accept++;
            if (q_instr.size() > 0) check_val("instr", 32'(instr), 32'(q_instr.pop_front()));
         end
         prev_req   = rom_req;
         prev_valid = instr_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_test(input logic [15:0] pc0, input int lat, input logic rdy);
      reset       = 1'b1;
      jmp_req     = 1'b0;
      jmp_target  = 16'h0;
      instr_ready = rdy;
      rom_lat     = lat;
      rom_inject  = 1'b0;
      pc_rst_val  = pc0;
      tick();
      tick();
      q_addr.delete();
      q_instr.delete();
      q_tgt.delete();
      n_accept = 0;
      n_inc    = 0;
      n_load   = 0;
      reset    = 1'b0;
   endtask

   task automatic end_test(input string tag);
      check_val({tag, "_drained"}, 32'(q_addr.size() + q_instr.size() + q_tgt.size()), 32'd0);
   endtask

   task automatic wait_accepts(input int n, input string tag);
      int k = 0;
      while (n_accept < n && k < 300) begin
         tick();
         k++;
      end
      check_val(tag, 32'(n_accept), 32'(n));
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (instr_valid !== 1'b1 && k < 100) begin
         tick();
         k++;
      end
      check_val(tag, 32'(instr_valid), 32'd1);
   endtask

   task automatic wait_req(input string tag);
      int k = 0;
      while (rom_req !== 1'b1 && k < 100) begin
         tick();
         k++;
      end
      check_val(tag, 32'(rom_req), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_pc_load"},     32'(pc_load),     32'd0);
      check_val({tag, "_pc_inc"},      32'(pc_inc),      32'd0);
      check_val({tag, "_pc_target"},   32'(pc_target),   32'd0);
      check_val({tag, "_rom_req"},     32'(rom_req),     32'd0);
      check_val({tag, "_rom_addr"},    32'(rom_addr),    32'd0);
      check_val({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      check_val({tag, "_instr"},       32'(instr),       32'd0);
   endtask

   initial begin
      int  k;
      logic got_ack;
      n_cmp = 0;
      n_err = 0;
      n_accept = 0;
      n_inc = 0;
      n_load = 0;
      reset = 1'b1;
      jmp_req = 1'b0;
      jmp_target = 16'h0;
      instr_ready = 1'b0;
      rom_lat = 1;
      rom_inject = 1'b0;
      pc_rst_val = 16'h0000;

      // Reset state
      tick();
      tick();
      check_all_zero("rst");

      // Sequential fetch from 0 with a 1-cycle ROM
      start_test(16'h0000, 1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         q_addr.push_back(16'(i));
         q_instr.push_back(rom_fn(16'(i)));
      end
      wait_accepts(3, "t1_accepts");
      check_val("t1_inc_count", 32'(n_inc), 32'd3);
      check_val("t1_load_count", 32'(n_load), 32'd0);
      end_test("t1");

      // ROM ack delayed 5 cycles
      start_test(16'h0100, 5, 1'b1);
      q_addr.push_back(16'h0100);
      q_instr.push_back(rom_fn(16'h0100));
      wait_req("t3_req");
      k = 0;
      got_ack = 1'b0;
      while (!got_ack && k < 50) begin
         #2;
         if (rom_ack) begin
            got_ack = 1'b1;
         end else begin
            check_val("t3_req_held", 32'(rom_req), 32'd1);
            tick();
            k++;
         end
      end
      check_val("t3_ack_seen", 32'(got_ack), 32'd1);
      check_val("t3_valid_at_ack", 32'(instr_valid), 32'd0);
      tick();
      check_val("t3_valid_after_ack", 32'(instr_valid), 32'd1);
      check_val("t3_instr_after_ack", 32'(instr), 32'(rom_fn(16'h0100)));
      wait_accepts(1, "t3_accepts");
      end_test("t3");

      // Decode stalls 4 cycles in HOLD
      start_test(16'h0200, 1, 1'b0);
      q_addr.push_back(16'h0200);
      q_addr.push_back(16'h0201);
      q_instr.push_back(rom_fn(16'h0200));
      q_instr.push_back(rom_fn(16'h0201));
      wait_valid("t4_valid");
      for (int i = 0; i < 4; i++) begin
         tick();
         check_val("t4_stall_valid", 32'(instr_valid), 32'd1);
         check_val("t4_stall_instr", 32'(instr), 32'(rom_fn(16'h0200)));
         check_val("t4_stall_noreq", 32'(rom_req), 32'd0);
      end
      instr_ready = 1'b1;
      wait_accepts(2, "t4_accepts");
      end_test("t4");

      // Jump while a word is held (ready high in the same cycle)
      start_test(16'h0300, 1, 1'b0);
      q_addr.push_back(16'h0300);
      q_addr.push_back(16'h0040);
      q_addr.push_back(16'h0041);
      q_instr.push_back(rom_fn(16'h0040));
      q_instr.push_back(rom_fn(16'h0041));
      q_tgt.push_back(16'h0040);
      wait_valid("t5_valid");
      jmp_req     = 1'b1;
      jmp_target  = 16'h0040;
      instr_ready = 1'b1;
      tick();
      jmp_req = 1'b0;
      check_val("t5_valid_drop", 32'(instr_valid), 32'd0);
      check_val("t5_pc_load", 32'(pc_load), 32'd1);
      check_val("t5_pc_target", 32'(pc_target), 32'h0040);
      wait_accepts(2, "t5_accepts");
      end_test("t5");

      // Jump with a request outstanding; ack 3 cycles later is discarded
      start_test(16'h0500, 4, 1'b1);
      q_addr.push_back(16'h0500);
      q_addr.push_back(16'h0080);
      q_addr.push_back(16'h0081);
      q_instr.push_back(rom_fn(16'h0080));
      q_instr.push_back(rom_fn(16'h0081));
      q_tgt.push_back(16'h0080);
      wait_req("t6_req");
      tick();
      jmp_req    = 1'b1;
      jmp_target = 16'h0080;
      tick();
      jmp_req = 1'b0;
      wait_accepts(2, "t6_accepts");
      check_val("t6_load_count", 32'(n_load), 32'd1);
      end_test("t6");

      // Second jump while draining: latest target wins
      start_test(16'h0700, 4, 1'b1);
      q_addr.push_back(16'h0700);
      q_addr.push_back(16'h0090);
      q_instr.push_back(rom_fn(16'h0090));
      q_tgt.push_back(16'h0080);
      q_tgt.push_back(16'h0090);
      wait_req("t6b_req");
      tick();
      jmp_req    = 1'b1;
      jmp_target = 16'h0080;
      tick();
      jmp_target = 16'h0090;
      tick();
      jmp_req = 1'b0;
      wait_accepts(1, "t6b_accepts");
      check_val("t6b_load_count", 32'(n_load), 32'd2);
      end_test("t6b");

      // PC wrap 16'hFFFF -> 16'h0000
      start_test(16'hFFFF, 1, 1'b1);
      q_addr.push_back(16'hFFFF);
      q_addr.push_back(16'h0000);
      q_instr.push_back(rom_fn(16'hFFFF));
      q_instr.push_back(rom_fn(16'h0000));
      wait_accepts(2, "t7_accepts");
      end_test("t7");

      // Reset while rom_req=1, then stray acks in IDLE/SETTLE
      start_test(16'h0600, 1, 1'b1);
      q_addr.push_back(16'h0600);
      q_addr.push_back(16'h0601);
      q_addr.push_back(16'h0600);
      q_instr.push_back(rom_fn(16'h0600));
      q_instr.push_back(rom_fn(16'h0600));
      wait_accepts(1, "t8_first");
      rom_lat = 10;
      wait_req("t8_req");
      reset = 1'b1;
      tick();
      check_all_zero("t8_mid_rst");
      reset      = 1'b0;
      rom_inject = 1'b1;
      tick();
      rom_lat = 1;
      tick();
      rom_inject = 1'b0;
      wait_accepts(2, "t8_accepts");
      check_val("t8_instr_final", 32'(instr), 32'(rom_fn(16'h0600)));
      end_test("t8");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_fetch_ctrl
`default_nettype wire
